// File: rtl/fwht_frame_ctrl.sv
// fwht_frame_ctrl
// Frame-level flow controller that sits in front of a fast Walsh-Hadamard
// transform core. A frame of N = 2^L_WIDTH beats is admitted only when the
// downstream output FIFO has room for the whole frame on top of everything
// already promised to earlier frames. Once admitted, upstream beats pass
// straight through to the core until N beats have been accepted. On the
// output side the controller counts core output beats, marks the last beat
// of each frame and retires the frame's FIFO reservation beat by beat.
//
// Ports
//   ACLK             : clock, all logic on the rising edge
//   ARESET           : synchronous active-high reset
//   enable           : allows a new frame to be admitted (sampled in IDLE only)
//   s_tvalid         : upstream beat valid
//   s_tready         : upstream beat ready (only while streaming)
//   core_tvalid      : beat valid towards the transform core input
//   core_tready      : transform core input ready
//   core_out_valid   : transform core output beat valid (no backpressure)
//   fifo_free        : free entries in the downstream output FIFO
//   m_tlast          : last output beat of a frame
//   frame_done       : one-cycle pulse in the cycle after m_tlast
//   frames_in_flight : frames admitted but not yet fully output (max 3)
//   busy             : controller not idle or frames still in flight
//   err_overrun      : sticky flag, output beat seen with nothing reserved

module fwht_frame_ctrl #(
    parameter int L_WIDTH = 12,
    parameter int CNT_W   = L_WIDTH + 2
) (
    input  logic             ACLK,
    input  logic             ARESET,
    input  logic             enable,
    input  logic             s_tvalid,
    output logic             s_tready,
    output logic             core_tvalid,
    input  logic             core_tready,
    input  logic             core_out_valid,
    input  logic [CNT_W-1:0] fifo_free,
    output logic             m_tlast,
    output logic             frame_done,
    output logic [1:0]       frames_in_flight,
    output logic             busy,
    output logic             err_overrun
);

    localparam int                 FRAME_BEATS   = 1 << L_WIDTH;
    localparam logic [CNT_W-1:0]   FRAME_LEN     = CNT_W'(FRAME_BEATS);
    localparam logic [CNT_W:0]     FRAME_LEN_EXT = (CNT_W + 1)'(FRAME_BEATS);
    localparam logic [L_WIDTH-1:0] LAST_BEAT     = '1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_CREDIT,
        STREAM
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [L_WIDTH-1:0] in_cnt;
    logic [L_WIDTH-1:0] out_cnt;
    logic [CNT_W-1:0]   reserved;

    logic credit_ok;
    logic admit;
    logic in_beat;
    logic last_in_beat;
    logic out_beat;
    logic out_expected;

    // The credit check is done one bit wider than the counters so that
    // reserved + N can never wrap and falsely appear to fit.
    assign credit_ok    = {1'b0, fifo_free} >= ({1'b0, reserved} + FRAME_LEN_EXT);
    assign admit        = (state == WAIT_CREDIT) && credit_ok && (frames_in_flight != 2'd3);
    assign in_beat      = (state == STREAM) && s_tvalid && core_tready;
    assign last_in_beat = in_beat && (in_cnt == LAST_BEAT);
    assign out_beat     = core_out_valid;
    assign out_expected = (reserved != '0);

    assign m_tlast = out_beat && (out_cnt == LAST_BEAT);
    assign busy    = (state != IDLE) || (frames_in_flight != 2'd0);

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The handshake towards the core is purely combinational so a streaming
    // frame adds no latency between upstream and the transform core.
    always_comb begin
        state_next  = state;
        s_tready    = 1'b0;
        core_tvalid = 1'b0;
        case (state)
            IDLE: begin
                if (enable && s_tvalid) begin
                    state_next = WAIT_CREDIT;
                end
            end
            WAIT_CREDIT: begin
                if (admit) begin
                    state_next = STREAM;
                end
            end
            STREAM: begin
                s_tready    = core_tready;
                core_tvalid = s_tvalid;
                if (last_in_beat) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Beat counters wrap naturally at N because they are exactly L_WIDTH
    // bits wide. The reservation only shrinks for output beats that were
    // actually reserved; an unreserved beat flags an overrun instead.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            in_cnt           <= '0;
            out_cnt          <= '0;
            reserved         <= '0;
            frames_in_flight <= 2'd0;
            err_overrun      <= 1'b0;
            frame_done       <= 1'b0;
        end else begin
            frame_done <= m_tlast;

            if (in_beat) begin
                in_cnt <= in_cnt + 1'b1;
            end

            if (out_beat) begin
                out_cnt <= out_cnt + 1'b1;
            end

            if (out_beat && !out_expected) begin
                err_overrun <= 1'b1;
            end

            case ({admit, out_beat && out_expected})
                2'b10:   reserved <= reserved + FRAME_LEN;
                2'b11:   reserved <= reserved + FRAME_LEN - CNT_W'(1);
                2'b01:   reserved <= reserved - CNT_W'(1);
                default: reserved <= reserved;
            endcase

            // Admission and completion in the same cycle cancel out.
            if (admit && !m_tlast) begin
                frames_in_flight <= frames_in_flight + 2'd1;
            end else if (!admit && m_tlast && (frames_in_flight != 2'd0)) begin
                frames_in_flight <= frames_in_flight - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_fwht_frame_ctrl.sv
// tb_fwht_frame_ctrl
// Directed scenarios followed by randomized traffic for fwht_frame_ctrl
// with L_WIDTH = 3 (N = 8). Every cycle the outputs are compared with a
// frame-level reference model kept in plain integers.

module tb_fwht_frame_ctrl;

    localparam int L_WIDTH = 3;
    localparam int CNT_W   = L_WIDTH + 2;
    localparam int N       = 1 << L_WIDTH;

    logic             ACLK = 1'b0;
    logic             ARESET;
    logic             enable;
    logic             s_tvalid;
    logic             s_tready;
    logic             core_tvalid;
    logic             core_tready;
    logic             core_out_valid;
    logic [CNT_W-1:0] fifo_free;
    logic             m_tlast;
    logic             frame_done;
    logic [1:0]       frames_in_flight;
    logic             busy;
    logic             err_overrun;

    int total = 0;
    int bad   = 0;

    // Reference model: mode 0 = idle, 1 = waiting for FIFO credit,
    // 2 = streaming a frame into the core.
    int mdl_mode;
    int mdl_in;
    int mdl_out;
    int mdl_res;
    int mdl_frames;
    bit mdl_err;
    bit mdl_done;

    fwht_frame_ctrl #(
        .L_WIDTH(L_WIDTH),
        .CNT_W  (CNT_W)
    ) dut (
        .ACLK            (ACLK),
        .ARESET          (ARESET),
        .enable          (enable),
        .s_tvalid        (s_tvalid),
        .s_tready        (s_tready),
        .core_tvalid     (core_tvalid),
        .core_tready     (core_tready),
        .core_out_valid  (core_out_valid),
        .fifo_free       (fifo_free),
        .m_tlast         (m_tlast),
        .frame_done      (frame_done),
        .frames_in_flight(frames_in_flight),
        .busy            (busy),
        .err_overrun     (err_overrun)
    );

    always #5 ACLK = ~ACLK;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        mdl_mode   = 0;
        mdl_in     = 0;
        mdl_out    = 0;
        mdl_res    = 0;
        mdl_frames = 0;
        mdl_err    = 1'b0;
        mdl_done   = 1'b0;
    endtask

    // Advance the model by one clock using the inputs that were applied.
    task automatic modelUpdate(input logic rst, input logic en, input logic sv,
                               input logic ct, input logic cov, input int ff);
        bit admit;
        bit in_beat;
        bit last_out;
        int next_mode;
        if (rst) begin
            modelReset();
        end else begin
            admit    = (mdl_mode == 1) && (ff >= mdl_res + N) && (mdl_frames < 3);
            in_beat  = (mdl_mode == 2) && sv && ct;
            last_out = cov && (mdl_out == N - 1);

            next_mode = mdl_mode;
            if (mdl_mode == 0 && en && sv) next_mode = 1;
            if (admit) next_mode = 2;
            if (in_beat && mdl_in == N - 1) next_mode = 0;

            if (cov && mdl_res == 0) mdl_err = 1'b1;
            mdl_res = mdl_res + (admit ? N : 0) - ((cov && mdl_res > 0) ? 1 : 0);

            if (admit && !last_out) mdl_frames++;
            else if (!admit && last_out && mdl_frames > 0) mdl_frames--;

            mdl_done = last_out;
            if (cov) mdl_out = (mdl_out + 1) % N;
            if (in_beat) mdl_in = (mdl_in + 1) % N;
            mdl_mode = next_mode;
        end
    endtask

    // One clock cycle: drive inputs on the falling edge, compare outputs
    // shortly after, then let the rising edge happen and step the model.
    task automatic applyStimulus(input logic rst, input logic en, input logic sv,
                                 input logic ct, input logic cov, input int ff);
        @(negedge ACLK);
        ARESET         = rst;
        enable         = en;
        s_tvalid       = sv;
        core_tready    = ct;
        core_out_valid = cov;
        fifo_free      = ff[CNT_W-1:0];
        #1;
        checkOutput("s_tready", 32'(s_tready), 32'((mdl_mode == 2) ? ct : 1'b0));
        checkOutput("core_tvalid", 32'(core_tvalid), 32'((mdl_mode == 2) ? sv : 1'b0));
        checkOutput("m_tlast", 32'(m_tlast), 32'(cov && (mdl_out == N - 1)));
        checkOutput("frame_done", 32'(frame_done), 32'(mdl_done));
        checkOutput("frames_in_flight", 32'(frames_in_flight), 32'(mdl_frames));
        checkOutput("busy", 32'(busy), 32'((mdl_mode != 0) || (mdl_frames != 0)));
        checkOutput("err_overrun", 32'(err_overrun), 32'(mdl_err));
        @(posedge ACLK);
        modelUpdate(rst, en, sv, ct, cov, ff);
    endtask

    initial begin
        ARESET         = 1'b1;
        enable         = 1'b0;
        s_tvalid       = 1'b0;
        core_tready    = 1'b0;
        core_out_valid = 1'b0;
        fifo_free      = '0;
        modelReset();

        // Reset state
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        #2;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_frames", 32'(frames_in_flight), 32'd0);

        // Not enough credit: hold in WAIT_CREDIT, then admit when room appears
        repeat (5) applyStimulus(0, 1, 1, 1, 0, 7);
        #2;
        checkOutput("credit_hold_ready", 32'(s_tready), 32'd0);
        applyStimulus(0, 1, 1, 1, 0, 8);
        #2;
        checkOutput("admit_ready", 32'(s_tready), 32'd1);
        checkOutput("admit_frames", 32'(frames_in_flight), 32'd1);
        repeat (8) applyStimulus(0, 0, 1, 1, 0, 8);
        #2;
        checkOutput("frame_in_end_ready", 32'(s_tready), 32'd0);
        checkOutput("frame_in_end_busy", 32'(busy), 32'd1);

        // Eight output beats retire the frame
        repeat (8) applyStimulus(0, 0, 0, 0, 1, 8);
        #2;
        checkOutput("frame_done_pulse", 32'(frame_done), 32'd1);
        checkOutput("frames_retired", 32'(frames_in_flight), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 8);
        #2;
        checkOutput("frame_done_single", 32'(frame_done), 32'd0);
        checkOutput("idle_busy", 32'(busy), 32'd0);

        // Unreserved output beat sets the sticky overrun flag
        applyStimulus(0, 0, 0, 0, 1, 8);
        repeat (4) applyStimulus(0, 0, 0, 0, 0, 8);
        #2;
        checkOutput("overrun_sticky", 32'(err_overrun), 32'd1);

        // Reset mid-frame discards the partial frame
        applyStimulus(1, 0, 0, 0, 0, 16);
        #2;
        checkOutput("overrun_cleared", 32'(err_overrun), 32'd0);
        applyStimulus(0, 1, 1, 1, 0, 16);
        applyStimulus(0, 1, 1, 1, 0, 16);
        repeat (5) applyStimulus(0, 0, 1, 1, 0, 16);
        applyStimulus(1, 0, 1, 1, 0, 16);
        #2;
        checkOutput("midframe_reset_ready", 32'(s_tready), 32'd0);
        checkOutput("midframe_reset_frames", 32'(frames_in_flight), 32'd0);
        applyStimulus(0, 1, 1, 1, 0, 16);
        applyStimulus(0, 1, 1, 1, 0, 16);
        repeat (7) applyStimulus(0, 0, 1, 1, 0, 16);
        #2;
        checkOutput("full_frame_needed", 32'(s_tready), 32'd1);
        applyStimulus(0, 0, 1, 1, 0, 16);
        #2;
        checkOutput("full_frame_done", 32'(s_tready), 32'd0);

        // Admission together with an output beat at reserved = 3 gives 10
        repeat (5) applyStimulus(0, 0, 0, 0, 1, 31);
        applyStimulus(0, 1, 1, 1, 0, 31);
        applyStimulus(0, 0, 1, 1, 1, 31);
        #2;
        checkOutput("coincide_frames", 32'(frames_in_flight), 32'd2);
        repeat (8) applyStimulus(0, 0, 1, 1, 0, 31);
        applyStimulus(0, 1, 1, 1, 0, 17);
        applyStimulus(0, 0, 1, 1, 0, 17);
        #2;
        checkOutput("reserved10_hold", 32'(s_tready), 32'd0);
        applyStimulus(0, 0, 1, 1, 0, 18);
        #2;
        checkOutput("reserved10_admit", 32'(s_tready), 32'd1);
        repeat (8) applyStimulus(0, 0, 1, 1, 0, 31);

        // Three frames in flight block further admission
        applyStimulus(0, 1, 1, 1, 0, 31);
        repeat (3) applyStimulus(0, 0, 1, 1, 0, 31);
        #2;
        checkOutput("saturate_hold", 32'(s_tready), 32'd0);
        checkOutput("saturate_frames", 32'(frames_in_flight), 32'd3);

        // Randomized traffic with occasional resets
        applyStimulus(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(logic'($urandom_range(0, 249) == 0),
                          logic'($urandom_range(0, 3) != 0),
                          logic'($urandom_range(0, 4) != 0),
                          logic'($urandom_range(0, 3) != 0),
                          logic'($urandom_range(0, 2) == 0),
                          int'($urandom_range(0, (1 << CNT_W) - 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
